// File: rtl/uart_tx_arb.sv
// uart_tx_arb
// Two-port arbiter feeding a single byte-wide UART transmitter.
// Each port has a small FIFO. A round-robin FSM pops one byte at a time,
// strobes it into the UART, waits for the UART to go busy (or times out),
// then waits for it to drain before granting again. At most one byte is
// in flight at a time.
//
// Ports:
//   clk, rst_n               clock (rising edge), async active-low reset
//   i_p0_data/valid, o_p0_ready   port 0 byte stream (sequencer results)
//   i_p1_data/valid, o_p1_ready   port 1 byte stream (register print/debug)
//   o_tx_data, o_tx_stb      byte and one-cycle send strobe to the UART
//   i_tx_busy                UART transmitter busy
//   o_p0_cnt, o_p1_cnt       wrapping counts of bytes completed per port
//   o_err                    sticky flag: UART never went busy after a strobe
module uart_tx_arb #(
    parameter int DW     = 8,
    parameter int DEPTH  = 2,
    parameter int ARM_TO = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [DW-1:0] i_p0_data,
    input  logic          i_p0_valid,
    output logic          o_p0_ready,
    input  logic [DW-1:0] i_p1_data,
    input  logic          i_p1_valid,
    output logic          o_p1_ready,
    output logic [DW-1:0] o_tx_data,
    output logic          o_tx_stb,
    input  logic          i_tx_busy,
    output logic [7:0]    o_p0_cnt,
    output logic [7:0]    o_p1_cnt,
    output logic          o_err
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam int TW = $clog2(ARM_TO + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        STB   = 2'd1,
        ARM   = 2'd2,
        DRAIN = 2'd3
    } state_t;

    // FIFO storage and bookkeeping, indexed by port
    logic [DW-1:0] mem_q   [2][DEPTH];
    logic [AW-1:0] wptr_q  [2];
    logic [AW-1:0] rptr_q  [2];
    logic [CW-1:0] fcnt_q  [2];

    logic [1:0]    push_s;
    logic [1:0]    pop_s;
    logic [1:0]    empty_s;
    logic [1:0]    ready_s;
    logic [DW-1:0] wdata_s [2];
    logic [DW-1:0] head_s  [2];

    // FSM and datapath registers
    state_t        state_q, state_d;
    logic          last_q;         // port granted most recently
    logic          gnt_s;          // port chosen this cycle
    logic          grant_s;        // a grant happens this cycle
    logic          done_s;         // the in-flight byte completes this cycle
    logic          err_set_s;
    logic [TW-1:0] arm_cnt_q, arm_cnt_d;
    logic [DW-1:0] data_q;
    logic          stb_q;
    logic [7:0]    p0_cnt_q;
    logic [7:0]    p1_cnt_q;
    logic          err_q;

    // Per-port FIFO status and handshake; ready is forced low while in reset
    always_comb begin
        wdata_s[0] = i_p0_data;
        wdata_s[1] = i_p1_data;
        for (int p = 0; p < 2; p++) begin
            empty_s[p] = (fcnt_q[p] == {CW{1'b0}});
            ready_s[p] = rst_n & (fcnt_q[p] != CW'(DEPTH));
            head_s[p]  = mem_q[p][rptr_q[p]];
        end
        push_s[0] = i_p0_valid & ready_s[0];
        push_s[1] = i_p1_valid & ready_s[1];
    end

    // FIFO storage writes (no reset needed: guarded by the counts)
    always_ff @(posedge clk) begin
        for (int p = 0; p < 2; p++) begin
            if (push_s[p]) begin
                mem_q[p][wptr_q[p]] <= wdata_s[p];
            end
        end
    end

    // FIFO pointers and occupancy counts
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int p = 0; p < 2; p++) begin
                wptr_q[p] <= {AW{1'b0}};
                rptr_q[p] <= {AW{1'b0}};
                fcnt_q[p] <= {CW{1'b0}};
            end
        end else begin
            for (int p = 0; p < 2; p++) begin
                if (push_s[p]) begin
                    wptr_q[p] <= wptr_q[p] + AW'(1);
                end
                if (pop_s[p]) begin
                    rptr_q[p] <= rptr_q[p] + AW'(1);
                end
                case ({push_s[p], pop_s[p]})
                    2'b10:   fcnt_q[p] <= fcnt_q[p] + CW'(1);
                    2'b01:   fcnt_q[p] <= fcnt_q[p] - CW'(1);
                    default: fcnt_q[p] <= fcnt_q[p];
                endcase
            end
        end
    end

    // Arbitration and transfer FSM next-state logic
    always_comb begin
        state_d   = state_q;
        arm_cnt_d = arm_cnt_q;
        gnt_s     = last_q;
        grant_s   = 1'b0;
        done_s    = 1'b0;
        err_set_s = 1'b0;
        pop_s     = 2'b00;
        case (state_q)
            IDLE: begin
                if (!i_tx_busy && (empty_s != 2'b11)) begin
                    // Tie goes to the port not served last
                    if (empty_s == 2'b00) begin
                        gnt_s = ~last_q;
                    end else if (!empty_s[0]) begin
                        gnt_s = 1'b0;
                    end else begin
                        gnt_s = 1'b1;
                    end
                    grant_s       = 1'b1;
                    pop_s[gnt_s]  = 1'b1;
                    state_d       = STB;
                end else begin
                    state_d = IDLE;
                end
            end
            STB: begin
                arm_cnt_d = {TW{1'b0}};
                state_d   = ARM;
            end
            ARM: begin
                if (i_tx_busy) begin
                    state_d = DRAIN;
                end else if (arm_cnt_q == TW'(ARM_TO - 1)) begin
                    // UART never acknowledged: flag it, but count the byte
                    err_set_s = 1'b1;
                    done_s    = 1'b1;
                    state_d   = IDLE;
                end else begin
                    arm_cnt_d = arm_cnt_q + TW'(1);
                end
            end
            DRAIN: begin
                if (!i_tx_busy) begin
                    done_s  = 1'b1;
                    state_d = IDLE;
                end else begin
                    state_d = DRAIN;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM state, grant pointer, output byte/strobe, counters and error flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            arm_cnt_q <= {TW{1'b0}};
            last_q    <= 1'b1;
            data_q    <= {DW{1'b0}};
            stb_q     <= 1'b0;
            p0_cnt_q  <= 8'd0;
            p1_cnt_q  <= 8'd0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            arm_cnt_q <= arm_cnt_d;
            stb_q     <= grant_s;
            if (grant_s) begin
                last_q <= gnt_s;
                data_q <= head_s[gnt_s];
            end
            // last_q still names the in-flight port until the next grant
            if (done_s) begin
                if (last_q) begin
                    p1_cnt_q <= p1_cnt_q + 8'd1;
                end else begin
                    p0_cnt_q <= p0_cnt_q + 8'd1;
                end
            end
            if (err_set_s) begin
                err_q <= 1'b1;
            end
        end
    end

    assign o_p0_ready = ready_s[0];
    assign o_p1_ready = ready_s[1];
    assign o_tx_data  = data_q;
    assign o_tx_stb   = stb_q;
    assign o_p0_cnt   = p0_cnt_q;
    assign o_p1_cnt   = p1_cnt_q;
    assign o_err      = err_q;

endmodule
